// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and helpers for the display path.
package vga_timing_pkg;

  localparam logic POL_ACTIVE_LOW  = 1'b0;
  localparam logic POL_ACTIVE_HIGH = 1'b1;

  // 640x480@60 from a 100 MHz board clock (25 MHz pixel rate)
  localparam int unsigned VGA640_CLK_DIV  = 32'd4;
  localparam int unsigned VGA640_H_ACTIVE = 32'd640;
  localparam int unsigned VGA640_H_FRONT  = 32'd16;
  localparam int unsigned VGA640_H_SYNC   = 32'd96;
  localparam int unsigned VGA640_H_BACK   = 32'd48;
  localparam int unsigned VGA640_V_ACTIVE = 32'd480;
  localparam int unsigned VGA640_V_FRONT  = 32'd10;
  localparam int unsigned VGA640_V_SYNC   = 32'd2;
  localparam int unsigned VGA640_V_BACK   = 32'd33;

  // 800x600@72 (50 MHz pixel rate), both syncs active-high
  localparam int unsigned SVGA800_CLK_DIV  = 32'd2;
  localparam int unsigned SVGA800_H_ACTIVE = 32'd800;
  localparam int unsigned SVGA800_H_FRONT  = 32'd56;
  localparam int unsigned SVGA800_H_SYNC   = 32'd120;
  localparam int unsigned SVGA800_H_BACK   = 32'd64;
  localparam int unsigned SVGA800_V_ACTIVE = 32'd600;
  localparam int unsigned SVGA800_V_FRONT  = 32'd37;
  localparam int unsigned SVGA800_V_SYNC   = 32'd6;
  localparam int unsigned SVGA800_V_BACK   = 32'd23;

  function automatic int unsigned timing_total(
    input int unsigned active,
    input int unsigned front,
    input int unsigned sync,
    input int unsigned back
  );
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Free-running clock divider producing a registered one-clk pixel enable.
module pixel_tick_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned DW = (CLK_DIV > 32'd1) ? $clog2(CLK_DIV) : 32'd1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 32'd1);

  logic [DW-1:0] r_div;
  logic [DW-1:0] w_div_next;
  logic          r_tick;

  // Next divider count: held at zero while cleared, wraps after DIV_LAST
  always_comb begin
    w_div_next = '0;
    if (clr) begin
      w_div_next = '0;
    end else if (r_div == DIV_LAST) begin
      w_div_next = '0;
    end else begin
      w_div_next = r_div + DW'(1);
    end
  end

  // Tick is registered from the next count so it is high while the divider sits at DIV_LAST
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_div  <= w_div_next;
      r_tick <= ~clr & (w_div_next == DIV_LAST);
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/vga_timing_gen.sv
// Configurable VGA raster timing: pixel enable, h/v counters, edge-aligned sync and
// blanking, line/frame strobes and a completed-frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV  = VGA640_CLK_DIV,
  parameter int unsigned H_ACTIVE = VGA640_H_ACTIVE,
  parameter int unsigned H_FRONT  = VGA640_H_FRONT,
  parameter int unsigned H_SYNC   = VGA640_H_SYNC,
  parameter int unsigned H_BACK   = VGA640_H_BACK,
  parameter int unsigned V_ACTIVE = VGA640_V_ACTIVE,
  parameter int unsigned V_FRONT  = VGA640_V_FRONT,
  parameter int unsigned V_SYNC   = VGA640_V_SYNC,
  parameter int unsigned V_BACK   = VGA640_V_BACK,
  parameter logic        HS_POL   = POL_ACTIVE_LOW,
  parameter logic        VS_POL   = POL_ACTIVE_LOW,
  parameter int unsigned CW       = 11
) (
  input  logic          clk100MHz,
  input  logic          reset,
  input  logic          enable,
  output logic          pTick,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          videoOn,
  output logic          hsync,
  output logic          vsync,
  output logic          lineStart,
  output logic          frameStart,
  output logic [15:0]   frameCount
);

  localparam int unsigned H_TOTAL   = timing_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL   = timing_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
  localparam int unsigned COORD_MAX = (32'd1 << CW) - 32'd1;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 32'd1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 32'd1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FRONT);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FRONT + H_SYNC - 32'd1);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FRONT);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FRONT + V_SYNC - 32'd1);

  if ((H_TOTAL - 32'd1) > COORD_MAX || (V_TOTAL - 32'd1) > COORD_MAX) begin : g_bad_cw
    $error("vga_timing_gen: CW too small for H_TOTAL-1 / V_TOTAL-1");
  end
  if (H_FRONT == 32'd0 || H_SYNC == 32'd0 || H_BACK == 32'd0 ||
      V_FRONT == 32'd0 || V_SYNC == 32'd0 || V_BACK == 32'd0 || CLK_DIV == 32'd0) begin : g_bad_timing
    $error("vga_timing_gen: porch, sync width and CLK_DIV must be non-zero");
  end

  logic          w_clr;
  logic          w_tick;
  logic          w_h_wrap;
  logic          w_v_wrap;
  logic          w_hs_act;
  logic          w_vs_act;
  logic          w_vid;
  logic [CW-1:0] w_x_next;
  logic [CW-1:0] w_y_next;
  logic [15:0]   w_frame_cnt_next;
  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic [15:0]   r_frame_cnt;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_video_on;

  assign w_clr = ~enable;

  pixel_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick_div (
    .clk   (clk100MHz),
    .reset (reset),
    .clr   (w_clr),
    .tick  (w_tick)
  );

  // Next raster position and frame count; syncs are decoded from these so they move with x/y
  always_comb begin
    w_h_wrap         = (r_x == H_LAST);
    w_v_wrap         = (r_y == V_LAST);
    w_x_next         = r_x;
    w_y_next         = r_y;
    w_frame_cnt_next = r_frame_cnt;
    if (!enable) begin
      w_x_next = '0;
      w_y_next = '0;
    end else if (w_tick) begin
      if (w_h_wrap) begin
        w_x_next = '0;
        if (w_v_wrap) begin
          w_y_next         = '0;
          w_frame_cnt_next = r_frame_cnt + 16'd1;
        end else begin
          w_y_next = r_y + CW'(1);
        end
      end else begin
        w_x_next = r_x + CW'(1);
      end
    end else begin
      w_x_next = r_x;
    end
    w_hs_act = enable & (w_x_next >= HS_START) & (w_x_next <= HS_END);
    w_vs_act = enable & (w_y_next >= VS_START) & (w_y_next <= VS_END);
    w_vid    = enable & (w_x_next < H_VIS) & (w_y_next < V_VIS);
  end

  // Raster state and aligned decode registers
  always_ff @(posedge clk100MHz or posedge reset) begin
    if (reset) begin
      r_x         <= '0;
      r_y         <= '0;
      r_frame_cnt <= 16'd0;
      r_hsync     <= ~HS_POL;
      r_vsync     <= ~VS_POL;
      r_video_on  <= 1'b0;
    end else begin
      r_x         <= w_x_next;
      r_y         <= w_y_next;
      r_frame_cnt <= w_frame_cnt_next;
      r_hsync     <= w_hs_act ? HS_POL : ~HS_POL;
      r_vsync     <= w_vs_act ? VS_POL : ~VS_POL;
      r_video_on  <= w_vid;
    end
  end

  assign pTick      = w_tick;
  assign x          = r_x;
  assign y          = r_y;
  assign videoOn    = r_video_on;
  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign lineStart  = w_tick & (r_x == '0);
  assign frameStart = w_tick & (r_x == '0) & (r_y == '0);
  assign frameCount = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed self-checking bench: default 640x480 line timing plus scaled-down
// instances for full-frame, polarity, CLK_DIV=1, enable-drop and mid-frame reset.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  int errors = 0;
  int checks = 0;

  logic d_pTick, d_videoOn, d_hsync, d_vsync, d_lineStart, d_frameStart;
  logic [10:0] d_x, d_y;
  logic [15:0] d_frameCount;
  logic s_pTick, s_videoOn, s_hsync, s_vsync, s_lineStart, s_frameStart;
  logic [4:0] s_x, s_y;
  logic [15:0] s_frameCount;
  logic p_pTick, p_videoOn, p_hsync, p_vsync, p_lineStart, p_frameStart;
  logic [4:0] p_x, p_y;
  logic [15:0] p_frameCount;
  logic t_pTick, t_videoOn, t_hsync, t_vsync, t_lineStart, t_frameStart;
  logic [3:0] t_x, t_y;
  logic [15:0] t_frameCount;

  vga_timing_gen u_def (
    .clk100MHz(clk), .reset(reset), .enable(enable), .pTick(d_pTick), .x(d_x), .y(d_y),
    .videoOn(d_videoOn), .hsync(d_hsync), .vsync(d_vsync), .lineStart(d_lineStart),
    .frameStart(d_frameStart), .frameCount(d_frameCount));

  vga_timing_gen #(.CLK_DIV(4), .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                   .V_ACTIVE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .CW(5)) u_sml (
    .clk100MHz(clk), .reset(reset), .enable(enable), .pTick(s_pTick), .x(s_x), .y(s_y),
    .videoOn(s_videoOn), .hsync(s_hsync), .vsync(s_vsync), .lineStart(s_lineStart),
    .frameStart(s_frameStart), .frameCount(s_frameCount));

  vga_timing_gen #(.CLK_DIV(2), .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                   .V_ACTIVE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
                   .HS_POL(1'b1), .VS_POL(1'b1), .CW(5)) u_pol (
    .clk100MHz(clk), .reset(reset), .enable(enable), .pTick(p_pTick), .x(p_x), .y(p_y),
    .videoOn(p_videoOn), .hsync(p_hsync), .vsync(p_vsync), .lineStart(p_lineStart),
    .frameStart(p_frameStart), .frameCount(p_frameCount));

  vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
                   .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .CW(4)) u_tny (
    .clk100MHz(clk), .reset(reset), .enable(enable), .pTick(t_pTick), .x(t_x), .y(t_y),
    .videoOn(t_videoOn), .hsync(t_hsync), .vsync(t_vsync), .lineStart(t_lineStart),
    .frameStart(t_frameStart), .frameCount(t_frameCount));

  always #5 clk = ~clk;

  task automatic test_reset();
    logic [43:0] dg;
    logic [31:0] sg, pg;
    logic [29:0] tg;
    repeat (2) @(negedge clk);
    dg = {d_pTick, d_x, d_y, d_videoOn, d_hsync, d_vsync, d_lineStart, d_frameStart, d_frameCount};
    sg = {s_pTick, s_x, s_y, s_videoOn, s_hsync, s_vsync, s_lineStart, s_frameStart, s_frameCount};
    pg = {p_pTick, p_x, p_y, p_videoOn, p_hsync, p_vsync, p_lineStart, p_frameStart, p_frameCount};
    tg = {t_pTick, t_x, t_y, t_videoOn, t_hsync, t_vsync, t_lineStart, t_frameStart, t_frameCount};
    checks++; if (dg !== {1'b0, 11'd0, 11'd0, 5'b01100, 16'd0}) begin errors++; $display("FAIL reset_def: got %h want %h", dg, {1'b0, 11'd0, 11'd0, 5'b01100, 16'd0}); end
    checks++; if (sg !== {1'b0, 5'd0, 5'd0, 5'b01100, 16'd0}) begin errors++; $display("FAIL reset_sml: got %h want %h", sg, {1'b0, 5'd0, 5'd0, 5'b01100, 16'd0}); end
    checks++; if (pg !== {1'b0, 5'd0, 5'd0, 5'b00000, 16'd0}) begin errors++; $display("FAIL reset_pol: got %h want %h", pg, {1'b0, 5'd0, 5'd0, 5'b00000, 16'd0}); end
    checks++; if (tg !== {1'b0, 4'd0, 4'd0, 5'b01100, 16'd0}) begin errors++; $display("FAIL reset_tny: got %h want %h", tg, {1'b0, 4'd0, 4'd0, 5'b01100, 16'd0}); end
  endtask

  // Called right after reset is released on a negedge: first pTick on the 3rd sample
  task automatic test_first_tick();
    int early = 0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (i < 3 && d_pTick !== 1'b0) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL first_tick_early: got %0d early ticks want 0", early); end
    checks++; if ({d_pTick, d_lineStart, d_frameStart, d_x, d_y} !== {3'b111, 11'd0, 11'd0}) begin
      errors++; $display("FAIL first_tick: got %b %b %b x=%0d y=%0d want 1 1 1 x=0 y=0", d_pTick, d_lineStart, d_frameStart, d_x, d_y); end
    @(negedge clk);
    checks++; if ({d_pTick, d_x} !== {1'b0, 11'd1}) begin errors++; $display("FAIL first_step: got tick=%b x=%0d want tick=0 x=1", d_pTick, d_x); end
  endtask

  // Two full default lines: pTick period, x wrap, hsync window, videoOn width
  task automatic test_def_line();
    int last_tick = 3, per_err = 0, hs_err = 0, vs_err = 0, vo_err = 0;
    int wraps = 0, wrap_err = 0, vo_l1 = 0, hs_l1 = 0, ls_l1 = 0;
    logic prev_tick = 1'b0;
    logic [10:0] prev_x = 11'd1, prev_y = 11'd0;
    for (int c = 5; c <= 6504; c++) begin
      @(negedge clk);
      if (d_pTick) begin
        if (c - last_tick != 4) per_err++;
        last_tick = c;
        if (d_y == 11'd1 && d_videoOn) vo_l1++;
        if (d_y == 11'd1 && !d_hsync) hs_l1++;
        if (d_y == 11'd1 && d_lineStart) ls_l1++;
      end
      if (d_hsync !== ~((d_x >= 11'd656) && (d_x <= 11'd751))) hs_err++;
      if (d_vsync !== ~((d_y >= 11'd490) && (d_y <= 11'd491))) vs_err++;
      if (d_videoOn !== ((d_x < 11'd640) && (d_y < 11'd480))) vo_err++;
      if (prev_tick && prev_x == 11'd799) begin
        wraps++;
        if (d_x !== 11'd0 || d_y !== prev_y + 11'd1) wrap_err++;
      end
      prev_tick = d_pTick; prev_x = d_x; prev_y = d_y;
    end
    checks++; if (per_err != 0) begin errors++; $display("FAIL def_period: got %0d bad gaps want 0", per_err); end
    checks++; if (hs_err != 0) begin errors++; $display("FAIL def_hsync: got %0d bad samples want 0", hs_err); end
    checks++; if (vs_err != 0) begin errors++; $display("FAIL def_vsync: got %0d bad samples want 0", vs_err); end
    checks++; if (vo_err != 0) begin errors++; $display("FAIL def_videoOn: got %0d bad samples want 0", vo_err); end
    checks++; if (wraps != 2 || wrap_err != 0) begin errors++; $display("FAIL def_xwrap: got %0d wraps %0d bad want 2 wraps 0 bad", wraps, wrap_err); end
    checks++; if (vo_l1 != 640) begin errors++; $display("FAIL def_vo_line: got %0d want 640", vo_l1); end
    checks++; if (hs_l1 != 96) begin errors++; $display("FAIL def_hs_line: got %0d want 96", hs_l1); end
    checks++; if (ls_l1 != 1) begin errors++; $display("FAIL def_lineStart: got %0d want 1", ls_l1); end
  endtask

  // Two+ frames of the scaled timing (23x15, CLK_DIV 4) plus the active-high polarity twin
  task automatic test_sml_frames(input string tag);
    int hs_err = 0, vs_err = 0, vo_err = 0, phs_err = 0, pvs_err = 0, fs_err = 0, first_err = 0;
    int gap_err = 0, vof_err = 0, wrap_err = 0, wraps = 0, nfs = 0, tick_cnt = 0, vo_cnt = 0;
    logic prev_tick = 1'b0;
    logic [4:0] prev_x = 5'd0, prev_y = 5'd0;
    logic [15:0] prev_fc = 16'd0;
    for (int i = 1; i <= 2800; i++) begin
      @(negedge clk);
      if (i < 3 && s_pTick !== 1'b0) first_err++;
      if (i == 3 && {s_pTick, s_frameStart, s_x, s_y, s_frameCount} !== {2'b11, 5'd0, 5'd0, 16'd0}) first_err++;
      if (s_hsync !== ~((s_x >= 5'd18) && (s_x <= 5'd20))) hs_err++;
      if (s_vsync !== ~((s_y >= 5'd10) && (s_y <= 5'd11))) vs_err++;
      if (s_videoOn !== ((s_x < 5'd16) && (s_y < 5'd8))) vo_err++;
      if (p_hsync !== ((p_x >= 5'd18) && (p_x <= 5'd20))) phs_err++;
      if (p_vsync !== ((p_y >= 5'd10) && (p_y <= 5'd11))) pvs_err++;
      if (s_frameStart !== (s_pTick && s_x == 5'd0 && s_y == 5'd0)) fs_err++;
      if (prev_tick && prev_x == 5'd22) begin
        if (prev_y == 5'd14) begin
          wraps++;
          if ({s_x, s_y, s_frameCount} !== {5'd0, 5'd0, prev_fc + 16'd1}) wrap_err++;
        end else if ({s_x, s_y, s_frameCount} !== {5'd0, prev_y + 5'd1, prev_fc}) begin
          wrap_err++;
        end
      end
      if (s_pTick) begin
        if (s_frameStart) begin
          if (nfs > 0 && tick_cnt != 345) gap_err++;
          if (nfs > 0 && vo_cnt != 128) vof_err++;
          nfs++; tick_cnt = 0; vo_cnt = 0;
        end
        tick_cnt++;
        if (s_videoOn) vo_cnt++;
      end
      prev_tick = s_pTick; prev_x = s_x; prev_y = s_y; prev_fc = s_frameCount;
    end
    checks++; if (first_err != 0) begin errors++; $display("FAIL %s_first_tick: got %0d bad want 0", tag, first_err); end
    checks++; if (hs_err != 0) begin errors++; $display("FAIL %s_hsync: got %0d bad want 0", tag, hs_err); end
    checks++; if (vs_err != 0) begin errors++; $display("FAIL %s_vsync: got %0d bad want 0", tag, vs_err); end
    checks++; if (vo_err != 0) begin errors++; $display("FAIL %s_videoOn: got %0d bad want 0", tag, vo_err); end
    checks++; if (phs_err != 0 || pvs_err != 0) begin errors++; $display("FAIL %s_pol_sync: got hs %0d vs %0d bad want 0 0", tag, phs_err, pvs_err); end
    checks++; if (fs_err != 0 || nfs != 3) begin errors++; $display("FAIL %s_frameStart: got %0d bad %0d pulses want 0 bad 3 pulses", tag, fs_err, nfs); end
    checks++; if (gap_err != 0 || vof_err != 0) begin errors++; $display("FAIL %s_frame_len: got %0d tick-gap %0d vo-count errors want 0 0", tag, gap_err, vof_err); end
    checks++; if (wraps != 2 || wrap_err != 0) begin errors++; $display("FAIL %s_wrap: got %0d frame wraps %0d bad want 2 0", tag, wraps, wrap_err); end
    checks++; if (s_frameCount !== 16'd2) begin errors++; $display("FAIL %s_frameCount: got %0d want 2", tag, s_frameCount); end
    checks++; if (p_frameCount !== 16'd4) begin errors++; $display("FAIL %s_pol_frameCount: got %0d want 4", tag, p_frameCount); end
  endtask

  task automatic test_sml_frame();
    reset = 1'b1; enable = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_sml_frames("sml");
  endtask

  // CLK_DIV=1, 7x6 raster: pTick every clk, frameStart every 42 clk
  task automatic test_tiny();
    int tick_err = 0, fs_err = 0, nfs = 0, hs_err = 0, vs_err = 0;
    reset = 1'b1; enable = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (t_pTick !== 1'b1) tick_err++;
      if (t_hsync !== (t_x != 4'd5)) hs_err++;
      if (t_vsync !== (t_y != 4'd4)) vs_err++;
      if (t_frameStart === 1'b1) begin
        nfs++;
        if ((i - 1) % 42 != 0 || t_frameCount !== 16'((i - 1) / 42)) fs_err++;
      end
    end
    checks++; if (tick_err != 0) begin errors++; $display("FAIL tny_tick: got %0d missing ticks want 0", tick_err); end
    checks++; if (hs_err != 0 || vs_err != 0) begin errors++; $display("FAIL tny_sync: got hs %0d vs %0d bad want 0 0", hs_err, vs_err); end
    checks++; if (nfs != 3 || fs_err != 0) begin errors++; $display("FAIL tny_frameStart: got %0d pulses %0d bad want 3 0", nfs, fs_err); end
    checks++; if (t_frameCount !== 16'd2) begin errors++; $display("FAIL tny_frameCount: got %0d want 2", t_frameCount); end
  endtask

  // Drop enable at (10,5) of the second frame for 10 clk, then restart
  task automatic test_enable_drop();
    int found = 0, hold_err = 0, early = 0;
    logic [15:0] fc;
    reset = 1'b1; enable = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3000 && found == 0; i++) begin
      @(negedge clk);
      if (s_pTick && s_x == 5'd10 && s_y == 5'd5 && s_frameCount == 16'd1) found = 1;
    end
    checks++; if (found == 0) begin errors++; $display("FAIL drop_reach: got not reached want (10,5) within 3000 clk"); end
    fc = s_frameCount;
    enable = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if ({s_pTick, s_x, s_y, s_videoOn, s_hsync, s_vsync, s_lineStart, s_frameStart} !== {1'b0, 5'd0, 5'd0, 5'b01100}) hold_err++;
      if (s_frameCount !== fc) hold_err++;
    end
    checks++; if (hold_err != 0) begin errors++; $display("FAIL drop_hold: got %0d bad samples want 0", hold_err); end
    checks++; if (s_frameCount !== 16'd1) begin errors++; $display("FAIL drop_frameCount: got %0d want 1", s_frameCount); end
    enable = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      if (j < 3 && s_pTick !== 1'b0) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL drop_restart_early: got %0d early ticks want 0", early); end
    checks++; if ({s_pTick, s_frameStart, s_x, s_y, s_frameCount} !== {2'b11, 5'd0, 5'd0, 16'd1}) begin
      errors++; $display("FAIL drop_restart: got tick=%b fs=%b x=%0d y=%0d fc=%0d want 1 1 0 0 1", s_pTick, s_frameStart, s_x, s_y, s_frameCount); end
  endtask

  // Asynchronous reset while hsync is active at (20,12), then a clean run
  task automatic test_reset_mid();
    int found = 0;
    logic [31:0] sg;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      @(negedge clk);
      if (s_x == 5'd20 && s_y == 5'd12) found = 1;
    end
    checks++; if (found == 0 || s_hsync !== 1'b0) begin errors++; $display("FAIL rstmid_reach: got found=%0d hsync=%b want 1 0", found, s_hsync); end
    #2 reset = 1'b1;
    #1 sg = {s_pTick, s_x, s_y, s_videoOn, s_hsync, s_vsync, s_lineStart, s_frameStart, s_frameCount};
    checks++; if (sg !== {1'b0, 5'd0, 5'd0, 5'b01100, 16'd0}) begin errors++; $display("FAIL rstmid_async: got %h want %h", sg, {1'b0, 5'd0, 5'd0, 5'b01100, 16'd0}); end
    @(negedge clk);
    reset = 1'b0;
    test_sml_frames("rstmid");
  endtask

  initial begin
    test_reset();
    reset = 1'b0;
    test_first_tick();
    test_def_line();
    test_sml_frame();
    test_tiny();
    test_enable_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
